// File: rtl/tl_cntr_nway.sv
// tl_cntr_nway: N-direction traffic-light controller, round-robin green.
// Optional pedestrian WALK phase when TL_CNTR_NWAY_PED_EN is defined.
module tl_cntr_nway #(
    parameter int NUM_DIR     = 4,
    parameter int TW          = 8,
    parameter int MIN_GREEN   = 8,
    parameter int MAX_GREEN   = 32,
    parameter int YELLOW_CYC  = 4,
    parameter int ALL_RED_CYC = 2,
`ifdef TL_CNTR_NWAY_PED_EN
    parameter int WALK_CYC    = 6,
`endif
    localparam int DW = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_DIR-1:0]   req,
`ifdef TL_CNTR_NWAY_PED_EN
    input  logic                 ped_req,
    output logic                 walk,
`endif
    output logic [2*NUM_DIR-1:0] light,
    output logic [DW-1:0]        active_dir,
    output logic [1:0]           phase
);

    typedef enum logic [1:0] {
        PH_GREEN   = 2'b00,
        PH_YELLOW  = 2'b01,
        PH_ALL_RED = 2'b10,
        PH_WALK    = 2'b11
    } phase_e;

    localparam logic [TW-1:0] T_MIN = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] T_MAX = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] T_YEL = TW'(YELLOW_CYC - 1);
    localparam logic [TW-1:0] T_AR  = TW'(ALL_RED_CYC - 1);
`ifdef TL_CNTR_NWAY_PED_EN
    localparam logic [TW-1:0] T_WLK = TW'(WALK_CYC - 1);
`endif

    localparam logic [2*NUM_DIR-1:0] RST_LIGHT =
        {{(2*NUM_DIR-2){1'b1}}, 2'b00};

    phase_e               phase_q;
    phase_e               phase_n;
    logic [DW-1:0]        dir_n;
    logic [DW-1:0]        nxt_q;
    logic [DW-1:0]        nxt_n;
    logic [TW-1:0]        timer;
    logic [TW-1:0]        timer_n;
    logic [TW-1:0]        timer_inc;
    logic [NUM_DIR-1:0]   other_mask;
    logic [DW-1:0]        scan_dir;
    logic [DW-1:0]        cand;
    logic                 found;
    logic                 ped_any;
    logic                 other_req;
    logic                 green_exit;

`ifdef TL_CNTR_NWAY_PED_EN
    logic ped_pend;
    logic walk_entry;

    assign ped_any    = ped_pend;
    assign walk_entry = (phase_n == PH_WALK) && (phase_q != PH_WALK);
`else
    assign ped_any = 1'b0;
`endif

    assign phase     = phase_q;
    assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

    // Lamp pattern for a given phase and owning direction.
    function automatic logic [2*NUM_DIR-1:0] lamp(
        input phase_e        ph,
        input logic [DW-1:0] d
    );
        logic [2*NUM_DIR-1:0] l;
        l = '1;
        for (int i = 0; i < NUM_DIR; i++) begin
            if (DW'(i) == d) begin
                if (ph == PH_GREEN) begin
                    l[2*i +: 2] = 2'b00;
                end else if (ph == PH_YELLOW) begin
                    l[2*i +: 2] = 2'b01;
                end
            end
        end
        return l;
    endfunction

    // Competing demand and round-robin pick of the next direction.
    always_comb begin
        other_mask             = req;
        other_mask[active_dir] = 1'b0;
        scan_dir               = active_dir;
        found                  = 1'b0;
        cand                   = '0;
        for (int k = 1; k < NUM_DIR; k++) begin
            cand = DW'((int'(active_dir) + k) % NUM_DIR);
            if (!found && req[cand]) begin
                found    = 1'b1;
                scan_dir = cand;
            end
        end
    end

    assign other_req  = (|other_mask) | ped_any;
    assign green_exit = (timer >= T_MIN) && other_req &&
                        (!req[active_dir] || (timer >= T_MAX));

    // Phase sequencing and timer next-state.
    always_comb begin
        phase_n = phase_q;
        dir_n   = active_dir;
        nxt_n   = nxt_q;
        timer_n = timer_inc;
        unique case (phase_q)
            PH_GREEN: begin
                if (green_exit) begin
                    phase_n = PH_YELLOW;
                    nxt_n   = scan_dir;
                    timer_n = '0;
                end
            end
            PH_YELLOW: begin
                if (timer == T_YEL) begin
                    phase_n = PH_ALL_RED;
                    timer_n = '0;
                end
            end
            PH_ALL_RED: begin
                if (timer == T_AR) begin
                    timer_n = '0;
                    if (ped_any) begin
                        phase_n = PH_WALK;
                    end else begin
                        phase_n = PH_GREEN;
                        dir_n   = nxt_q;
                    end
                end
            end
`ifdef TL_CNTR_NWAY_PED_EN
            PH_WALK: begin
                if (timer == T_WLK) begin
                    phase_n = PH_ALL_RED;
                    timer_n = '0;
                end
            end
`endif
            default: begin
                phase_n = PH_GREEN;
                dir_n   = '0;
                nxt_n   = '0;
                timer_n = '0;
            end
        endcase
    end

    // Controller state and registered lamp outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q    <= PH_GREEN;
            active_dir <= '0;
            nxt_q      <= '0;
            timer      <= '0;
            light      <= RST_LIGHT;
        end else begin
            phase_q    <= phase_n;
            active_dir <= dir_n;
            nxt_q      <= nxt_n;
            timer      <= timer_n;
            light      <= lamp(phase_n, dir_n);
        end
    end

`ifdef TL_CNTR_NWAY_PED_EN
    // Sticky pedestrian request and registered walk lamp.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_pend <= 1'b0;
            walk     <= 1'b0;
        end else begin
            ped_pend <= ped_req | (ped_pend & ~walk_entry);
            walk     <= (phase_n == PH_WALK);
        end
    end
`endif

endmodule
